// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
// Owner encoding doubles as the arbiter FSM state.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CORE = 2'd1,
        OWN_ACC  = 2'd2
    } owner_e;

    localparam int unsigned DEF_MAX_BURST = 4;

    // Pick this cycle's owner from both requests, the previous owner and
    // whether the previous owner has used up its burst allowance.
    function automatic owner_e pick_winner(
        input logic   core_req,
        input logic   acc_req,
        input owner_e last_owner,
        input logic   burst_spent
    );
        owner_e w;
        w = OWN_NONE;
        if (core_req && acc_req) begin
            if (last_owner == OWN_NONE) begin
                w = OWN_CORE;
            end else if (!burst_spent) begin
                w = last_owner;
            end else begin
                w = (last_owner == OWN_CORE) ? OWN_ACC : OWN_CORE;
            end
        end else if (core_req) begin
            w = OWN_CORE;
        end else if (acc_req) begin
            w = OWN_ACC;
        end else begin
            w = OWN_NONE;
        end
        return w;
    endfunction

endpackage

// File: rtl/dmem_arb_stats.sv
// Saturating activity counters for the data-memory arbiter.
// Only instantiated when DMEM_ARB_STATS_EN is defined.
module dmem_arb_stats #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             core_gnt_i,
    input  logic             acc_gnt_i,
    input  logic             conflict_i,
    output logic [WIDTH-1:0] stat_core_gnt_o,
    output logic [WIDTH-1:0] stat_acc_gnt_o,
    output logic [WIDTH-1:0] stat_conflict_o
);

    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

    logic [WIDTH-1:0] core_cnt_q;
    logic [WIDTH-1:0] acc_cnt_q;
    logic [WIDTH-1:0] conf_cnt_q;

    // Count grant and conflict cycles, holding at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            core_cnt_q <= {WIDTH{1'b0}};
            acc_cnt_q  <= {WIDTH{1'b0}};
            conf_cnt_q <= {WIDTH{1'b0}};
        end else begin
            if (core_gnt_i && (core_cnt_q != CNT_MAX)) begin
                core_cnt_q <= core_cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
            end
            if (acc_gnt_i && (acc_cnt_q != CNT_MAX)) begin
                acc_cnt_q <= acc_cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
            end
            if (conflict_i && (conf_cnt_q != CNT_MAX)) begin
                conf_cnt_q <= conf_cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
            end
        end
    end

    assign stat_core_gnt_o = core_cnt_q;
    assign stat_acc_gnt_o  = acc_cnt_q;
    assign stat_conflict_o = conf_cnt_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the core MEM stage and an
// accelerator/loader port. Grants are combinational; the previous owner
// and its burst length are registered so neither side starves for more
// than MAX_BURST cycles. Optional stats counters: DMEM_ARB_STATS_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned MAX_BURST  = DEF_MAX_BURST
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  core_req,
    input  logic                  core_we,
    input  logic [ADDR_WIDTH-1:0] core_addr,
    input  logic [WIDTH-1:0]      core_wdata,
    output logic                  core_gnt,
    output logic [WIDTH-1:0]      core_rdata,
    output logic                  core_stall,
    input  logic                  acc_req,
    input  logic                  acc_we,
    input  logic [ADDR_WIDTH-1:0] acc_addr,
    input  logic [WIDTH-1:0]      acc_wdata,
    output logic                  acc_gnt,
    output logic [WIDTH-1:0]      acc_rdata,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]      mem_wdata,
    input  logic [WIDTH-1:0]      mem_rdata
`ifdef DMEM_ARB_STATS_EN
    ,
    output logic [WIDTH-1:0]      stat_core_gnt,
    output logic [WIDTH-1:0]      stat_acc_gnt,
    output logic [WIDTH-1:0]      stat_conflict
`endif
);

    localparam int unsigned       CNT_W     = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0]  BURST_MAX = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    owner_e           last_owner_q;
    owner_e           last_owner_d;
    owner_e           winner_s;
    logic [CNT_W-1:0] burst_cnt_q;
    logic [CNT_W-1:0] burst_cnt_d;

    // Choose this cycle's owner; nobody is granted while reset is held.
    always_comb begin
        winner_s = OWN_NONE;
        if (!rst) begin
            winner_s = OWN_NONE;
        end else begin
            winner_s = pick_winner(core_req, acc_req, last_owner_q,
                                   burst_cnt_q >= BURST_MAX);
        end
    end

    // Steer the memory port from the winner and gate grants and read data.
    always_comb begin
        core_gnt  = 1'b0;
        acc_gnt   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = {ADDR_WIDTH{1'b0}};
        mem_wdata = {WIDTH{1'b0}};
        case (winner_s)
            OWN_CORE: begin
                core_gnt  = 1'b1;
                mem_we    = core_we;
                mem_addr  = core_addr;
                mem_wdata = core_wdata;
            end
            OWN_ACC: begin
                acc_gnt   = 1'b1;
                mem_we    = acc_we;
                mem_addr  = acc_addr;
                mem_wdata = acc_wdata;
            end
            default: begin
                core_gnt  = 1'b0;
                acc_gnt   = 1'b0;
            end
        endcase
        core_stall = rst & core_req & ~core_gnt;
        core_rdata = rst ? mem_rdata : {WIDTH{1'b0}};
        acc_rdata  = rst ? mem_rdata : {WIDTH{1'b0}};
    end

    // Next owner/burst: idle clears, a repeat grant extends, a switch restarts.
    always_comb begin
        last_owner_d = last_owner_q;
        burst_cnt_d  = burst_cnt_q;
        if (winner_s == OWN_NONE) begin
            last_owner_d = OWN_NONE;
            burst_cnt_d  = {CNT_W{1'b0}};
        end else if (winner_s == last_owner_q) begin
            last_owner_d = last_owner_q;
            burst_cnt_d  = (burst_cnt_q >= BURST_MAX) ? BURST_MAX
                                                      : burst_cnt_q + CNT_ONE;
        end else begin
            last_owner_d = winner_s;
            burst_cnt_d  = CNT_ONE;
        end
    end

    // Owner/burst state register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_owner_q <= OWN_NONE;
            burst_cnt_q  <= {CNT_W{1'b0}};
        end else begin
            last_owner_q <= last_owner_d;
            burst_cnt_q  <= burst_cnt_d;
        end
    end

`ifdef DMEM_ARB_STATS_EN
    dmem_arb_stats #(
        .WIDTH (WIDTH)
    ) u_stats (
        .clk             (clk),
        .rst             (rst),
        .core_gnt_i      (core_gnt),
        .acc_gnt_i       (acc_gnt),
        .conflict_i      (core_req & acc_req),
        .stat_core_gnt_o (stat_core_gnt),
        .stat_acc_gnt_o  (stat_acc_gnt),
        .stat_conflict_o (stat_conflict)
    );
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a vector table followed by
// hand-written multi-cycle arbitration sequences, with a scoreboard queue.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_req, core_we, acc_req, acc_we;
    logic [31:0] core_addr, core_wdata, acc_addr, acc_wdata;
    logic        core_gnt, core_stall, acc_gnt, mem_we;
    logic [31:0] core_rdata, acc_rdata, mem_addr, mem_wdata, mem_rdata;
`ifdef DMEM_ARB_STATS_EN
    logic [31:0] stat_core_gnt, stat_acc_gnt, stat_conflict;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        r;
        logic        cr, cw;
        logic [31:0] ca, cd;
        logic        ar, aw;
        logic [31:0] aa, ad;
        logic        gc, ga;
        string       name;
    } vec_t;

    typedef struct {
        logic        gc, ga, stall, we;
        logic [31:0] addr, wdata;
        logic        chk_c, chk_a;
        logic [31:0] rd_c, rd_a;
        string       name;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] mem_arr [0:63];
    logic [31:0] ref_mem [0:63];
    logic        mem_clr = 1'b1;

    always #5 clk = ~clk;

    dmem_arbiter #(.WIDTH(32), .ADDR_WIDTH(32), .MAX_BURST(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_gnt   (core_gnt),
        .core_rdata (core_rdata),
        .core_stall (core_stall),
        .acc_req    (acc_req),
        .acc_we     (acc_we),
        .acc_addr   (acc_addr),
        .acc_wdata  (acc_wdata),
        .acc_gnt    (acc_gnt),
        .acc_rdata  (acc_rdata),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
`ifdef DMEM_ARB_STATS_EN
        ,
        .stat_core_gnt (stat_core_gnt),
        .stat_acc_gnt  (stat_acc_gnt),
        .stat_conflict (stat_conflict)
`endif
    );

    // Behavioural single-port memory: combinational read, write at posedge.
    assign mem_rdata = mem_arr[mem_addr[7:2]];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 64; i++) mem_arr[i] <= 32'h0;
        end else if (mem_we) begin
            mem_arr[mem_addr[7:2]] <= mem_wdata;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Drive one cycle, queue its expectation, then sample mid-cycle and compare.
    task automatic step(input vec_t v);
        exp_t e;
        exp_t g;
        @(negedge clk);
        rst = v.r;
        core_req = v.cr; core_we = v.cw; core_addr = v.ca; core_wdata = v.cd;
        acc_req  = v.ar; acc_we  = v.aw; acc_addr  = v.aa; acc_wdata  = v.ad;
        e.name  = v.name;
        e.gc    = v.gc;
        e.ga    = v.ga;
        e.stall = v.r & v.cr & ~v.gc;
        e.we    = 1'b0; e.addr = 32'h0; e.wdata = 32'h0;
        if (v.gc) begin
            e.we = v.cw; e.addr = v.ca; e.wdata = v.cd;
        end else if (v.ga) begin
            e.we = v.aw; e.addr = v.aa; e.wdata = v.ad;
        end
        e.chk_c = !v.r || v.gc;
        e.chk_a = !v.r || v.ga;
        e.rd_c  = v.r ? ref_mem[v.ca[7:2]] : 32'h0;
        e.rd_a  = v.r ? ref_mem[v.aa[7:2]] : 32'h0;
        exp_q.push_back(e);
        #4;
        g = exp_q.pop_front();
        chk({g.name, ".core_gnt"},   {31'h0, core_gnt},   {31'h0, g.gc});
        chk({g.name, ".acc_gnt"},    {31'h0, acc_gnt},    {31'h0, g.ga});
        chk({g.name, ".core_stall"}, {31'h0, core_stall}, {31'h0, g.stall});
        chk({g.name, ".mem_we"},     {31'h0, mem_we},     {31'h0, g.we});
        chk({g.name, ".mem_addr"},   mem_addr,  g.addr);
        chk({g.name, ".mem_wdata"},  mem_wdata, g.wdata);
        if (g.chk_c) chk({g.name, ".core_rdata"}, core_rdata, g.rd_c);
        if (g.chk_a) chk({g.name, ".acc_rdata"},  acc_rdata,  g.rd_a);
        if (g.we) ref_mem[g.addr[7:2]] = g.wdata;
    endtask

    task automatic cyc(input logic r, input logic cr, input logic ar,
                       input logic gc, input logic ga, input string nm);
        vec_t v;
        v = '{r: r, cr: cr, cw: 1'b0, ca: 32'h10, cd: 32'h0000_00C0,
              ar: ar, aw: 1'b0, aa: 32'h20, ad: 32'h0000_00AC,
              gc: gc, ga: ga, name: nm};
        step(v);
    endtask

    vec_t tbl[10];

    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = 32'h0;
        rst = 1'b0;
        core_req = 1'b0; core_we = 1'b0; core_addr = 32'h0; core_wdata = 32'h0;
        acc_req  = 1'b0; acc_we  = 1'b0; acc_addr  = 32'h0; acc_wdata  = 32'h0;
        @(negedge clk);
        mem_clr = 1'b0;

        //         r     cr    cw    ca      cd            ar    aw    aa      ad            gc    ga
        tbl[0] = '{1'b0, 1'b1, 1'b1, 32'h10, 32'h1111_1111, 1'b1, 1'b1, 32'h20, 32'h2222_2222, 1'b0, 1'b0, "rst_force0"};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 32'h10, 32'h1111_1111, 1'b1, 1'b1, 32'h20, 32'h2222_2222, 1'b0, 1'b0, "rst_force1"};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0,  32'h0,         1'b1, 1'b0, "core_store"};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 32'h10, 32'h0000_0055, 1'b0, 1'b0, 32'h0,  32'h0,         1'b1, 1'b0, "core_load"};
        tbl[4] = '{1'b1, 1'b0, 1'b0, 32'h0,  32'h0,         1'b1, 1'b1, 32'h20, 32'h1234_5678, 1'b0, 1'b1, "acc_store"};
        tbl[5] = '{1'b1, 1'b0, 1'b0, 32'h0,  32'h0,         1'b1, 1'b0, 32'h20, 32'h0000_0066, 1'b0, 1'b1, "acc_load"};
        tbl[6] = '{1'b1, 1'b1, 1'b1, 32'h0,  32'hA5A5_A5A5, 1'b0, 1'b0, 32'h0,  32'h0,         1'b1, 1'b0, "core_st0"};
        tbl[7] = '{1'b1, 1'b0, 1'b1, 32'h30, 32'h7777_7777, 1'b0, 1'b1, 32'h34, 32'h8888_8888, 1'b0, 1'b0, "idle"};
        tbl[8] = '{1'b1, 1'b1, 1'b0, 32'h10, 32'h0,         1'b1, 1'b0, 32'h20, 32'h0,         1'b1, 1'b0, "tie_none"};
        tbl[9] = '{1'b1, 1'b0, 1'b0, 32'h0,  32'h0,         1'b0, 1'b0, 32'h0,  32'h0,         1'b0, 1'b0, "idle2"};
        for (int i = 0; i < 10; i++) step(tbl[i]);

        // Continuous contention from reset: CORE 4, ACC 4, CORE 4.
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "tie_rst");
        for (int i = 1; i <= 12; i++) begin
            if (i >= 5 && i <= 8) cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, $sformatf("tie_c%0d", i));
            else                  cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, $sformatf("tie_c%0d", i));
        end
`ifdef DMEM_ARB_STATS_EN
        @(posedge clk); #1;
        chk("stat_core_gnt", stat_core_gnt, 32'd8);
        chk("stat_acc_gnt",  stat_acc_gnt,  32'd4);
        chk("stat_conflict", stat_conflict, 32'd12);
`endif

        // Idle cycle clears ownership: CORE wins the tie and starts at burst 1.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "idl_a");
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "idl_acc");
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "idl_b");
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "idl_core");
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, "idl_switch");

        // Reset in the middle of an ACC burst.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "mid_idle");
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "mid_acc1");
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "mid_acc2");
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, "mid_rst");
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "mid_after");

        // Loser drops its request while ACC sits at a saturated burst.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "drop_idle");
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "drop_core");
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, "drop_acc");
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "drop_alone1");
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, "drop_alone2");
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, "drop_return");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
